// File: rtl/xevious_rom_loader_pkg.sv
// xevious_rom_pkg
//   Shared constants and types for the Xevious ROM loader.
//   - ROM_AW / ROM_NREG / ROM_IMG_SIZE: image geometry defaults
//   - REG_BASE[0..ROM_NREG]: linear-image base of each region, the last entry
//     being the end of the final region
//     (cpu1, cpu2, cpu3, gfx_fg, gfx_bg, gfx_sp, tiles, proms)
//   - ldr_state_e: loader FSM states
//   - REGIONS_FIT: elaboration-time check that every region fits a 15-bit
//     local address and that the table ends inside the image
package xevious_rom_pkg;

    localparam int unsigned ROM_AW    = 17;
    localparam int unsigned ROM_NREG  = 8;
    localparam int unsigned REGION_AW = 15;

    localparam logic [ROM_AW-1:0] ROM_IMG_SIZE = 17'h1_2B00;
    localparam logic [ROM_AW-1:0] REGION_MAX   = 17'h0_8000;

    localparam logic [ROM_AW-1:0] REG_BASE [0:ROM_NREG] = '{
        17'h0_0000,   // cpu1   16 KB
        17'h0_4000,   // cpu2    8 KB
        17'h0_6000,   // cpu3    4 KB
        17'h0_7000,   // gfx_fg  4 KB
        17'h0_8000,   // gfx_bg  8 KB
        17'h0_A000,   // gfx_sp 24 KB
        17'h1_0000,   // tiles   8 KB
        17'h1_2000,   // proms 2.5 KB
        17'h1_2A00    // end of proms; bytes up to the image end are padding
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } ldr_state_e;

    function automatic bit regions_fit();
        for (int unsigned r = 0; r < ROM_NREG; r++) begin
            if (REG_BASE[r+1] < REG_BASE[r])
                return 1'b0;
            if ((REG_BASE[r+1] - REG_BASE[r]) > REGION_MAX)
                return 1'b0;
        end
        return (REG_BASE[ROM_NREG] <= ROM_IMG_SIZE);
    endfunction

    localparam bit REGIONS_FIT = regions_fit();

endpackage

// File: rtl/xevious_rom_loader_if.sv
// xevious_rom_loader_if
//   Bundles the ioctl download stream (dl_*) and the ROM-side write port plus
//   loader status. The 'slave' modport is the loader; 'master' is the
//   hps_io / core side.
//   dl_active  : download of index 0 in progress
//   dl_wr      : 1-clk byte strobe
//   dl_addr    : linear image address
//   dl_data    : image byte
//   rom_we     : one-hot region write strobe
//   rom_addr   : region-local address
//   rom_data   : write data
//   byte_cnt   : bytes accepted this download
//   rom_ready  : complete valid image loaded
//   load_err   : last download was bad
//   core_reset : active-high core reset
interface xevious_rom_loader_if
    import xevious_rom_pkg::*;
#(
    parameter int unsigned NREG = ROM_NREG,
    parameter int unsigned AW   = ROM_AW
);

    logic            dl_active;
    logic            dl_wr;
    logic [AW-1:0]   dl_addr;
    logic [7:0]      dl_data;

    logic [NREG-1:0] rom_we;
    logic [14:0]     rom_addr;
    logic [7:0]      rom_data;
    logic [AW-1:0]   byte_cnt;
    logic            rom_ready;
    logic            load_err;
    logic            core_reset;

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  rom_we, rom_addr, rom_data, byte_cnt, rom_ready, load_err, core_reset
    );

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output rom_we, rom_addr, rom_data, byte_cnt, rom_ready, load_err, core_reset
    );

endinterface

// File: rtl/xevious_rom_region_dec.sv
// xevious_rom_region_dec
//   Combinational decode of a linear image address into a one-hot region
//   select and the address local to that region. Addresses outside every
//   region give sel_o = 0 and offset_o = 0.
//   addr_i   : linear image address
//   sel_o    : one-hot region select (bit r <=> REG_BASE[r] <= addr < REG_BASE[r+1])
//   offset_o : addr_i - REG_BASE[r]
module xevious_rom_region_dec
    import xevious_rom_pkg::*;
(
    input  logic [ROM_AW-1:0]    addr_i,
    output logic [ROM_NREG-1:0]  sel_o,
    output logic [REGION_AW-1:0] offset_o
);

    if (!REGIONS_FIT) begin : g_region_size_chk
        $error("xevious_rom_pkg: REG_BASE has a region over 32 KB or ends past the image");
    end

    always_comb begin
        sel_o    = '0;
        offset_o = '0;
        for (int unsigned r = 0; r < ROM_NREG; r++) begin
            if ((addr_i >= REG_BASE[r]) && (addr_i < REG_BASE[r+1])) begin
                sel_o[r] = 1'b1;
                offset_o = REGION_AW'(addr_i - REG_BASE[r]);
            end
        end
    end

endmodule

// File: rtl/xevious_rom_loader.sv
// xevious_rom_loader
//   Turns the hps_io ioctl stream for ROM index 0 into per-region write
//   strobes, counts accepted bytes, validates the image length/ordering and
//   holds the Xevious core in reset until a complete image is loaded.
//   clk_sys : system clock (hps_io domain)
//   reset_n : asynchronous active-low reset
//   bus     : xevious_rom_loader_if.slave (download stream in, ROM port and
//             status out)
module xevious_rom_loader
    import xevious_rom_pkg::*;
#(
    parameter int unsigned     AW       = ROM_AW,
    parameter int unsigned     NREG     = ROM_NREG,
    parameter logic [AW-1:0]   IMG_SIZE = ROM_IMG_SIZE
)
(
    input  logic                  clk_sys,
    input  logic                  reset_n,
    xevious_rom_loader_if.slave   bus
);

    if ((AW != ROM_AW) || (NREG != ROM_NREG)) begin : g_geom_chk
        $error("xevious_rom_loader: AW/NREG must match the region table in xevious_rom_pkg");
    end

    ldr_state_e      state_q, state_d;
    logic            dl_active_q;
    logic [AW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            err_seq_q, err_seq_d;
    logic            err_long_q, err_long_d;
    logic            rom_ready_q, rom_ready_d;
    logic            load_err_q, load_err_d;
    logic [NREG-1:0] rom_we_q, rom_we_d;
    logic [14:0]     rom_addr_q, rom_addr_d;
    logic [7:0]      rom_data_q, rom_data_d;

    logic [NREG-1:0] dec_sel;
    logic [14:0]     dec_off;
    logic            dl_rise;
    logic            in_seq;
    logic            in_range;

    xevious_rom_region_dec u_dec (
        .addr_i   (bus.dl_addr),
        .sel_o    (dec_sel),
        .offset_o (dec_off)
    );

    assign dl_rise  = bus.dl_active & ~dl_active_q;
    assign in_seq   = (bus.dl_addr == byte_cnt_q);
    // Keeping acceptance below IMG_SIZE is what saturates byte_cnt.
    assign in_range = (byte_cnt_q < IMG_SIZE);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        err_seq_d   = err_seq_q;
        err_long_d  = err_long_q;
        rom_ready_d = rom_ready_q;
        load_err_d  = load_err_q;
        rom_we_d    = '0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (dl_rise) begin
                    state_d     = ST_LOAD;
                    byte_cnt_d  = '0;
                    err_seq_d   = 1'b0;
                    err_long_d  = 1'b0;
                    rom_ready_d = 1'b0;
                    load_err_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                // A strobe arriving with the dl_active fall is still taken,
                // so CHECK sees the final count.
                if (bus.dl_wr) begin
                    if (in_seq && in_range) begin
                        rom_we_d   = dec_sel;
                        rom_addr_d = dec_off;
                        rom_data_d = bus.dl_data;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end else begin
                        if (!in_range)
                            err_long_d = 1'b1;
                        if (!in_seq)
                            err_seq_d = 1'b1;
                    end
                end
                if (!bus.dl_active)
                    state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if ((byte_cnt_q == IMG_SIZE) && !err_seq_q && !err_long_q) begin
                    state_d     = ST_DONE;
                    rom_ready_d = 1'b1;
                end else begin
                    state_d    = ST_FAIL;
                    load_err_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dl_active_q <= 1'b0;
            byte_cnt_q  <= '0;
            err_seq_q   <= 1'b0;
            err_long_q  <= 1'b0;
            rom_ready_q <= 1'b0;
            load_err_q  <= 1'b0;
            rom_we_q    <= '0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            dl_active_q <= bus.dl_active;
            byte_cnt_q  <= byte_cnt_d;
            err_seq_q   <= err_seq_d;
            err_long_q  <= err_long_d;
            rom_ready_q <= rom_ready_d;
            load_err_q  <= load_err_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
        end
    end

    assign bus.rom_we     = rom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_data   = rom_data_q;
    assign bus.byte_cnt   = byte_cnt_q;
    assign bus.rom_ready  = rom_ready_q;
    assign bus.load_err   = load_err_q;
    assign bus.core_reset = ~rom_ready_q | (state_q == ST_LOAD) | (state_q == ST_CHECK);

endmodule

// File: tb/tb_xevious_rom_loader.sv
// tb_xevious_rom_loader
//   Two loader instances share clock and reset:
//   - dut_b: image length 0x7006, streamed once end to end so that the
//     region boundaries up to gfx_fg (including REG_BASE[3]+5) are crossed
//   - dut_s: image length 300, used for the table of download scenarios and
//     the reset / re-download sequences
//   Stimulus goes to whichever instance 'tgt' selects (0 = dut_s, 1 = dut_b).
module tb_xevious_rom_loader;

    localparam logic [16:0] N_S = 17'd300;
    localparam logic [16:0] N_B = 17'h0_7006;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        act   = 1'b0;
    logic        wr    = 1'b0;
    logic        tgt   = 1'b0;
    logic [16:0] addr_v = '0;
    logic [7:0]  data_v = '0;

    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned pulses_s = 0;
    int unsigned pulses_b = 0;

    always #5 clk = ~clk;

    xevious_rom_loader_if bus_s ();
    xevious_rom_loader_if bus_b ();

    assign bus_s.dl_active = act & ~tgt;
    assign bus_s.dl_wr     = wr  & ~tgt;
    assign bus_s.dl_addr   = addr_v;
    assign bus_s.dl_data   = data_v;
    assign bus_b.dl_active = act & tgt;
    assign bus_b.dl_wr     = wr  & tgt;
    assign bus_b.dl_addr   = addr_v;
    assign bus_b.dl_data   = data_v;

    xevious_rom_loader #(.IMG_SIZE(N_S)) dut_s (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus_s)
    );

    xevious_rom_loader #(.IMG_SIZE(N_B)) dut_b (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus_b)
    );

    always @(negedge clk) begin
        if (bus_s.rom_we != '0) pulses_s <= pulses_s + 1;
        if (bus_b.rom_we != '0) pulses_b <= pulses_b + 1;
    end

    typedef struct {
        int unsigned nbytes;
        int unsigned skip_at;      // 0 = no skip, else addresses from here on are +1
        bit          extra;        // one more write at address IMG_SIZE
        bit          end_with_wr;  // last write coincides with dl_active fall
        logic        exp_ready;
        logic        exp_err;
        logic [16:0] exp_cnt;
        int unsigned exp_pulses;
    } scen_t;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_we;
        logic [14:0] exp_ra;
    } cp_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte write; outputs sampled in the cycle after the strobe.
    task automatic wr_byte(input logic [16:0] a, input logic [7:0] d, input bit drop_act,
                           output logic [7:0] we, output logic [14:0] ra, output logic [7:0] rd);
        addr_v = a;
        data_v = d;
        wr     = 1'b1;
        if (drop_act) act = 1'b0;
        tick();
        wr = 1'b0;
        we = tgt ? bus_b.rom_we   : bus_s.rom_we;
        ra = tgt ? bus_b.rom_addr : bus_s.rom_addr;
        rd = tgt ? bus_b.rom_data : bus_s.rom_data;
        if (!drop_act) tick();
    endtask

    task automatic run_scen(input scen_t s, input int idx);
        logic [7:0]  we;
        logic [14:0] ra;
        logic [7:0]  rd;
        logic [16:0] a;
        int unsigned p0;
        bit          last;
        tgt = 1'b0;
        p0  = pulses_s;
        act = 1'b1;
        tick();
        tick();
        for (int unsigned i = 0; i < s.nbytes; i++) begin
            a    = (s.skip_at != 0 && i >= s.skip_at) ? 17'(i + 1) : 17'(i);
            last = s.end_with_wr && !s.extra && (i == s.nbytes - 1);
            wr_byte(a, 8'(i) + 8'h11, last, we, ra, rd);
        end
        if (s.extra) begin
            wr_byte(N_S, 8'hEE, 1'b0, we, ra, rd);
            check($sformatf("s%0d extra byte strobe", idx), 32'(we), 32'h0);
        end
        if (act) begin
            act = 1'b0;
            tick();
        end
        check($sformatf("s%0d core_reset in CHECK", idx), 32'(bus_s.core_reset), 32'h1);
        tick();
        check($sformatf("s%0d rom_ready", idx),  32'(bus_s.rom_ready),  32'(s.exp_ready));
        check($sformatf("s%0d load_err", idx),   32'(bus_s.load_err),   32'(s.exp_err));
        check($sformatf("s%0d byte_cnt", idx),   32'(bus_s.byte_cnt),   32'(s.exp_cnt));
        check($sformatf("s%0d strobes", idx),    pulses_s - p0,         s.exp_pulses);
        check($sformatf("s%0d core_reset", idx), 32'(bus_s.core_reset), 32'(!s.exp_ready));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        scen_t       scens [0:4];
        cp_t         cps   [0:7];
        logic [7:0]  we;
        logic [14:0] ra;
        logic [7:0]  rd;
        logic [7:0]  d;
        int unsigned cp;
        bit          hit;

        //             nbytes skip extra endwr ready err  cnt      pulses
        scens[0] = '{  300,   0,   0,    0,    1'b1, 1'b0, 17'd300, 300 };
        scens[1] = '{  299,   0,   0,    0,    1'b0, 1'b1, 17'd299, 299 };
        scens[2] = '{  300,   0,   1,    0,    1'b0, 1'b1, 17'd300, 300 };
        scens[3] = '{  3,     2,   0,    0,    1'b0, 1'b1, 17'd2,   2   };
        scens[4] = '{  300,   0,   0,    1,    1'b1, 1'b0, 17'd300, 300 };

        //           addr         data   we     local addr
        cps[0] = '{ 17'h0_0000, 8'h12, 8'h01, 15'h0000 };
        cps[1] = '{ 17'h0_3FFF, 8'h34, 8'h01, 15'h3FFF };
        cps[2] = '{ 17'h0_4000, 8'h56, 8'h02, 15'h0000 };
        cps[3] = '{ 17'h0_5234, 8'h78, 8'h02, 15'h1234 };
        cps[4] = '{ 17'h0_6000, 8'h9A, 8'h04, 15'h0000 };
        cps[5] = '{ 17'h0_6FFF, 8'hBC, 8'h04, 15'h0FFF };
        cps[6] = '{ 17'h0_7000, 8'hDE, 8'h08, 15'h0000 };
        cps[7] = '{ 17'h0_7005, 8'hA5, 8'h08, 15'h0005 };

        // Reset values
        tick();
        tick();
        check("rst rom_we",     32'(bus_s.rom_we),     32'h0);
        check("rst rom_addr",   32'(bus_s.rom_addr),   32'h0);
        check("rst rom_data",   32'(bus_s.rom_data),   32'h0);
        check("rst byte_cnt",   32'(bus_s.byte_cnt),   32'h0);
        check("rst rom_ready",  32'(bus_s.rom_ready),  32'h0);
        check("rst load_err",   32'(bus_s.load_err),   32'h0);
        check("rst core_reset", 32'(bus_s.core_reset), 32'h1);
        check("rst b core_reset", 32'(bus_b.core_reset), 32'h1);
        rst_n = 1'b1;
        tick();
        check("idle core_reset", 32'(bus_s.core_reset), 32'h1);

        // Long image streamed through the region boundaries
        tgt = 1'b1;
        act = 1'b1;
        tick();
        tick();
        cp = 0;
        for (int unsigned a = 0; a < 32'(N_B); a++) begin
            hit = (cp < 8) && (17'(a) == cps[cp].addr);
            d   = hit ? cps[cp].data : (8'(a) ^ 8'h3C);
            wr_byte(17'(a), d, 1'b0, we, ra, rd);
            if (hit) begin
                check($sformatf("cp%0d rom_we", cp),   32'(we), 32'(cps[cp].exp_we));
                check($sformatf("cp%0d rom_addr", cp), 32'(ra), 32'(cps[cp].exp_ra));
                check($sformatf("cp%0d rom_data", cp), 32'(rd), 32'(cps[cp].data));
                cp++;
            end
        end
        check("big checkpoints reached", cp, 8);
        act = 1'b0;
        tick();
        check("big CHECK core_reset", 32'(bus_b.core_reset), 32'h1);
        check("big CHECK rom_ready",  32'(bus_b.rom_ready),  32'h0);
        tick();
        check("big rom_ready",  32'(bus_b.rom_ready),  32'h1);
        check("big load_err",   32'(bus_b.load_err),   32'h0);
        check("big core_reset", 32'(bus_b.core_reset), 32'h0);
        check("big byte_cnt",   32'(bus_b.byte_cnt),   32'(N_B));
        check("big strobes",    pulses_b,              32'(N_B));

        // Download scenarios on the short image
        for (int i = 0; i < 5; i++)
            run_scen(scens[i], i);

        // Strobe while DONE is ignored
        tgt = 1'b0;
        wr_byte(N_S, 8'h77, 1'b0, we, ra, rd);
        check("done wr rom_we",   32'(we),               32'h0);
        check("done wr byte_cnt", 32'(bus_s.byte_cnt),   32'(N_S));
        check("done wr ready",    32'(bus_s.rom_ready),  32'h1);
        check("done core_reset",  32'(bus_s.core_reset), 32'h0);

        // Second download after DONE
        act = 1'b1;
        tick();
        check("redl rom_ready",  32'(bus_s.rom_ready),  32'h0);
        check("redl core_reset", 32'(bus_s.core_reset), 32'h1);
        check("redl byte_cnt",   32'(bus_s.byte_cnt),   32'h0);
        tick();
        for (int unsigned i = 0; i < 99; i++)
            wr_byte(17'(i), 8'(i) + 8'h11, 1'b0, we, ra, rd);

        // Reset right after the strobe of byte 99
        addr_v = 17'd99;
        data_v = 8'h74;
        wr     = 1'b1;
        tick();
        wr = 1'b0;
        check("pre-rst rom_we", 32'(bus_s.rom_we), 32'h01);
        rst_n = 1'b0;
        #1;
        check("mid rst rom_we",     32'(bus_s.rom_we),     32'h0);
        check("mid rst rom_addr",   32'(bus_s.rom_addr),   32'h0);
        check("mid rst rom_data",   32'(bus_s.rom_data),   32'h0);
        check("mid rst byte_cnt",   32'(bus_s.byte_cnt),   32'h0);
        check("mid rst rom_ready",  32'(bus_s.rom_ready),  32'h0);
        check("mid rst load_err",   32'(bus_s.load_err),   32'h0);
        check("mid rst core_reset", 32'(bus_s.core_reset), 32'h1);
        tick();
        act = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst byte_cnt", 32'(bus_s.byte_cnt), 32'h0);

        // Fresh full download after the aborted one
        run_scen(scens[0], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
